// File: rtl/eth_ingress_pkt_buffer.sv
// Store-and-forward ingress packet buffer: collects MAC words tentatively, publishes a packet
// to the switch core only once its eop word is stored, and drops bad or oversize packets.
module eth_ingress_pkt_buffer #(
    parameter int DEPTH     = 512,
    parameter int MAX_WORDS = 380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [1:0]  rx_bv,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    output logic [31:0] out_data,
    output logic [1:0]  out_bv,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic        drop_pulse,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [35:0]   mem [DEPTH];
    logic [PW-1:0] wr_tent;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [CW-1:0] word_cnt;

    logic [PW-1:0] base_ptr;
    logic [PW-1:0] used;
    logic [CW-1:0] cnt_inc;
    logic          buf_full;
    logic          too_long;
    logic          rd_fire;
    logic [35:0]   rd_entry;

    logic [PW-1:0] wr_tent_nxt;
    logic [PW-1:0] wr_commit_nxt;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          do_write;
    logic          drop_evt;
    logic          start_pkt;

    // A sop arriving mid-packet rolls back first, so its space check sees the committed pointer.
    assign base_ptr = (state == ST_RECV && rx_sop) ? wr_commit : wr_tent;
    assign used     = base_ptr - rd_ptr;
    assign buf_full = (used == PW'(DEPTH));
    assign cnt_inc  = word_cnt + 1'b1;
    assign too_long = !rx_eop && (cnt_inc == CW'(MAX_WORDS));

    always_comb begin
        state_nxt     = state;
        wr_tent_nxt   = wr_tent;
        wr_commit_nxt = wr_commit;
        cnt_nxt       = word_cnt;
        do_write      = 1'b0;
        drop_evt      = 1'b0;
        start_pkt     = 1'b0;

        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_sop) begin
                        start_pkt = 1'b1;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (rx_sop) begin
                        drop_evt  = 1'b1;
                        start_pkt = 1'b1;
                    end else if (buf_full || too_long) begin
                        // An eop word that overflows already closes the packet, so no DROP wait.
                        wr_tent_nxt = wr_commit;
                        drop_evt    = 1'b1;
                        state_nxt   = rx_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        do_write    = 1'b1;
                        wr_tent_nxt = wr_tent + 1'b1;
                        cnt_nxt     = cnt_inc;
                        if (rx_eop) begin
                            wr_commit_nxt = wr_tent + 1'b1;
                            state_nxt     = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (rx_eop) begin
                        state_nxt = ST_IDLE;
                    end else if (rx_sop) begin
                        start_pkt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (start_pkt) begin
            if (buf_full || (!rx_eop && MAX_WORDS == 1)) begin
                wr_tent_nxt = wr_commit;
                drop_evt    = 1'b1;
                state_nxt   = rx_eop ? ST_IDLE : ST_DROP;
            end else begin
                do_write    = 1'b1;
                wr_tent_nxt = base_ptr + 1'b1;
                cnt_nxt     = CW'(1);
                if (rx_eop) begin
                    wr_commit_nxt = base_ptr + 1'b1;
                    state_nxt     = ST_IDLE;
                end else begin
                    state_nxt = ST_RECV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            mem[base_ptr[AW-1:0]] <= {rx_data, rx_bv, rx_sop, rx_eop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_tent    <= '0;
            wr_commit  <= '0;
            rd_ptr     <= '0;
            state      <= ST_IDLE;
            word_cnt   <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wr_tent    <= wr_tent_nxt;
            wr_commit  <= wr_commit_nxt;
            state      <= state_nxt;
            word_cnt   <= cnt_nxt;
            drop_pulse <= drop_evt;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop_evt && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign rd_entry  = mem[rd_ptr[AW-1:0]];
    assign out_valid = !reset && (rd_ptr != wr_commit);
    assign rd_fire   = out_valid && out_ready;
    assign out_data  = rd_entry[35:4];
    assign out_bv    = rd_entry[3:2];
    assign out_sop   = rd_entry[1];
    assign out_eop   = rd_entry[0];

endmodule

// File: tb/tb_eth_ingress_pkt_buffer.sv
// Scoreboard bench for eth_ingress_pkt_buffer: committed packets are queued as they are sent
// and every word leaving the buffer is popped and compared.
module tb_eth_ingress_pkt_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [1:0]  rx_bv;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic [31:0] out_data;
    logic [1:0]  out_bv;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
    logic        drop_pulse;
    logic [15:0] drop_cnt;

    logic [35:0] exp_q[$];
    int          total_checks = 0;
    int          bad_checks   = 0;
    int          exp_drops    = 0;
    int          exp_pulses   = 0;
    int          pulses_seen  = 0;

    eth_ingress_pkt_buffer #(.DEPTH(512), .MAX_WORDS(380)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_bv      (rx_bv),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .out_data   (out_data),
        .out_bv     (out_bv),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] bv, input logic sop, input logic eop);
        rx_data  = d;
        rx_bv    = bv;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Words are queued only when the eop of a packet expected to survive is driven.
    task automatic send_pkt(input int n, input logic [31:0] base, input logic [1:0] last_bv,
                            input bit with_eop, input bit expect_ok);
        logic [35:0] pend[$];
        logic [31:0] d;
        logic [1:0]  bv;
        logic        sop;
        logic        eop;
        for (int i = 0; i < n; i++) begin
            d   = base + 32'(i);
            sop = (i == 0);
            eop = with_eop && (i == n - 1);
            bv  = eop ? last_bv : 2'($urandom_range(0, 3));
            pend.push_back({d, bv, sop, eop});
            if (eop && expect_ok) begin
                foreach (pend[k]) exp_q.push_back(pend[k]);
            end
            applyStimulus(d, bv, sop, eop);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("empty_after_drain", 64'(out_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (drop_pulse === 1'b1) pulses_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                checkOutput("out_word", 64'({out_data, out_bv, out_sop, out_eop}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        rx_data   = '0;
        rx_bv     = '0;
        rx_valid  = 1'b0;
        rx_sop    = 1'b0;
        rx_eop    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("rst_drop_pulse", 64'(drop_pulse), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 4-word packet: nothing visible until eop is written, then sop word next cycle
        exp_q.push_back({32'hA000_0001, 2'b01, 1'b1, 1'b0});
        exp_q.push_back({32'hA000_0002, 2'b11, 1'b0, 1'b0});
        exp_q.push_back({32'hA000_0003, 2'b00, 1'b0, 1'b0});
        exp_q.push_back({32'hA000_0004, 2'b10, 1'b0, 1'b1});
        applyStimulus(32'hA000_0001, 2'b01, 1'b1, 1'b0);
        applyStimulus(32'hA000_0002, 2'b11, 1'b0, 1'b0);
        applyStimulus(32'hA000_0003, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sf_before_eop", 64'(out_valid), 64'd0);
        applyStimulus(32'hA000_0004, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("lat_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_sop_word", 64'({out_data, out_sop}), 64'({32'hA000_0001, 1'b1}));
        wait_drain(50);
        checkOutput("t1_drop_cnt", 64'(drop_cnt), 64'd0);

        // Fragment cut short by a new sop, then an intact 3-word packet
        send_pkt(2, 32'hB000_0000, 2'b00, 1'b0, 1'b0);
        exp_drops++;
        exp_pulses++;
        send_pkt(3, 32'hC000_0000, 2'b11, 1'b1, 1'b1);
        wait_drain(50);
        checkOutput("frag_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        checkOutput("frag_pulses", 64'(pulses_seen), 64'(exp_pulses));

        // Single-word packet
        send_pkt(1, 32'h1234_5678, 2'b00, 1'b1, 1'b1);
        wait_drain(20);

        // Fill the buffer with out_ready low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            send_pkt(100, 32'h1000_0000 + (32'(p) << 16), 2'(p), 1'b1, 1'b1);
        end
        send_pkt(100, 32'h2000_0000, 2'b01, 1'b1, 1'b0);
        exp_drops++;
        exp_pulses++;
        send_pkt(12, 32'h3000_0000, 2'b10, 1'b1, 1'b1);
        send_pkt(2, 32'h4000_0000, 2'b11, 1'b1, 1'b0);
        exp_drops++;
        exp_pulses++;
        @(negedge clk);
        checkOutput("full_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("full_hold_word", 64'({out_data, out_bv, out_sop, out_eop}), 64'(exp_q[0]));
        repeat (3) @(negedge clk);
        checkOutput("full_hold_stable", 64'({out_data, out_bv, out_sop, out_eop}), 64'(exp_q[0]));
        checkOutput("full_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(700);

        // Oversize packet dropped, exact-maximum packet and a short one pass, stray word dropped
        send_pkt(400, 32'h5000_0000, 2'b00, 1'b1, 1'b0);
        exp_drops++;
        exp_pulses++;
        send_pkt(380, 32'h6000_0000, 2'b01, 1'b1, 1'b1);
        send_pkt(5, 32'h7000_0000, 2'b10, 1'b1, 1'b1);
        wait_drain(500);
        checkOutput("long_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        applyStimulus(32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
        exp_drops++;
        exp_pulses++;
        @(negedge clk);
        checkOutput("stray_pulse", 64'(drop_pulse), 64'd1);
        @(negedge clk);
        checkOutput("stray_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        checkOutput("pulse_total", 64'(pulses_seen), 64'(exp_pulses));

        // Reset mid-packet with two committed packets waiting
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_pkt(4, 32'h8000_0000, 2'b00, 1'b1, 1'b1);
        send_pkt(4, 32'h8100_0000, 2'b01, 1'b1, 1'b1);
        send_pkt(3, 32'h8200_0000, 2'b10, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        @(negedge clk);
        checkOutput("postrst_valid", 64'(out_valid), 64'd0);
        checkOutput("postrst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_pkt(4, 32'h9000_0000, 2'b11, 1'b1, 1'b1);
        wait_drain(50);
        checkOutput("final_drop_cnt", 64'(drop_cnt), 64'(exp_drops));

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/eth_ingress_pkt_buffer.md
ETH_INGRESS_PKT_BUFFER -- requirements
Module: eth_ingress_pkt_buffer

Interface
REQ-001 Parameter DEPTH, default 512, storage entries (power of two, >= MAX_WORDS).
REQ-002 Parameter MAX_WORDS, default 380, maximum accepted packet length in 32-bit words.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  32  MAC receive data word.
REQ-006 rx_bv  input  2  valid bytes on eop word: 00=4, 01=1, 10=2, 11=3; ignored on non-eop words.
REQ-007 rx_valid  input  1  rx word present this cycle; no backpressure toward MAC.
REQ-008 rx_sop  input  1  first word of packet.
REQ-009 rx_eop  input  1  last word of packet.
REQ-010 out_data  output  32  word to switch core.
REQ-011 out_bv  output  2  stored rx_bv of the word.
REQ-012 out_valid  output  1  out word present.
REQ-013 out_sop  output  1  stored sop.
REQ-014 out_eop  output  1  stored eop.
REQ-015 out_ready  input  1  switch core accepts word.
REQ-016 drop_pulse  output  1  one-cycle pulse per dropped packet or stray word.
REQ-017 drop_cnt  output  16  saturating count of drop events.

Function
REQ-018 Store-and-forward: no word of a packet SHALL appear on out_* until its eop word is written (commit).
REQ-019 Each entry SHALL hold {data, bv, sop, eop}; pointers wr_tent, wr_commit, rd_ptr are log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-020 Write FSM states: IDLE, RECV, DROP; reset state IDLE.
REQ-021 IDLE, rx_valid & rx_sop: write word at wr_tent, wr_tent+1, word count=1; if rx_eop also set, commit and stay IDLE, else go RECV.
REQ-022 IDLE, rx_valid & !rx_sop: discard word, drop_pulse, stay IDLE.
REQ-023 RECV, rx_valid & !rx_sop: write word, count+1; on rx_eop commit (wr_commit <= wr_tent+1) and go IDLE.
REQ-024 RECV, rx_valid & rx_sop: roll back wr_tent to wr_commit, drop_pulse, then treat word as new packet start per REQ-021 in the same cycle.
REQ-025 Overflow: word arriving when wr_tent - rd_ptr == DEPTH, or a non-eop word that would make count == MAX_WORDS, SHALL roll back wr_tent to wr_commit, drop_pulse, go DROP (word not written).
REQ-026 DROP: discard all words; rx_valid & rx_eop returns to IDLE; rx_valid & rx_sop & !rx_eop enters RECV per REQ-021 (resync).
REQ-027 Read side: out_valid = (rd_ptr != wr_commit); out_* = entry[rd_ptr] combinationally; out_* SHALL hold stable while out_valid & !out_ready.
REQ-028 Transfer on out_valid & out_ready: rd_ptr+1 next cycle.
REQ-029 Latency: eop written at edge N SHALL give out_valid high in cycle after edge N (sop word of that packet) when buffer was otherwise empty.
REQ-030 Simultaneous write and read in one cycle SHALL both take effect; space check uses rd_ptr before that cycle's read.
REQ-031 Rollback never affects rd_ptr or already committed packets.
REQ-032 drop_cnt increments by 1 per drop_pulse, saturates at 16'hFFFF.
REQ-033 Packets SHALL exit in arrival order with words, bv, sop, eop bit-exact.

Reset
REQ-034 While reset high: all pointers 0, FSM IDLE, count 0, drop_cnt 0, drop_pulse 0, out_valid 0; storage contents not reset.
REQ-035 Reset asserted mid-packet or mid-readout SHALL discard all stored and partial packets; first packet after reset starts clean.

Verification
REQ-036 4-word packet (sop word 0xA0000001, eop bv=10), out_ready=1 -> out_valid one cycle after eop write, 4 identical words out, out_bv=10 on eop, drop_cnt=0.
REQ-037 Packet of 2 words then new sop without eop, followed by 3-word packet -> first fragment never output, drop_pulse once, drop_cnt=1, 3-word packet output intact.
REQ-038 Single-word packet sop=eop=1, data 0x12345678 -> stored and output as one word with out_sop=out_eop=1.
REQ-039 out_ready=0, send packets until full (DEPTH=512) -> packet crossing capacity dropped, state DROP until its eop, earlier packets intact; release out_ready -> all committed packets drain in order.
REQ-040 Packet of 400 words (> MAX_WORDS) -> dropped at word 380, drop_cnt+1, next normal packet passes; stray non-sop word in IDLE -> drop_cnt+1.
REQ-041 Reset asserted during packet receive with 2 committed packets queued -> out_valid=0 next cycle, drop_cnt=0, subsequent packet passes normally.
